// File: rtl/riscv_mc_core.sv
// riscv_mc_core: multi-cycle RV32I-subset core (ADD, SUB, ADDI, LW, SW, BEQ, BNE).
// A single req/ack memory port is shared by instruction fetch and data accesses.
// A control FSM steps through FETCH/DECODE/EXECUTE/MEM/WB.
// Optional feature macro: RV_ILLEGAL_TRAP_EN. When it is defined, an illegal
// instruction stops the core in HALT. When it is undefined, the instruction
// retires as a NOP.
module riscv_mc_core #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] a0,
  output logic            retire,
  output logic            halted
);

  localparam int              RIDX    = $clog2(NREGS);
  localparam logic [5:0]      NREGS_W = 6'(NREGS);
  localparam logic [RIDX-1:0] A0_IDX  = RIDX'(10);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q, imm_q, result_q, addr_q;
  logic [XLEN-1:0] regs [NREGS];
  logic            retire_q;
  logic            req_en;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode  = ir[6:0];
  assign rd_idx  = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1_idx = ir[19:15];
  assign rs2_idx = ir[24:20];
  assign funct7  = ir[31:25];

  logic is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_bne;
  logic uses_rs1, uses_rs2, uses_rd, idx_bad, illegal;
  logic is_alu, is_ldst, is_branch;

  // Classify the held instruction and flag unsupported encodings or register indices
  always_comb begin
    is_add  = 1'b0;
    is_sub  = 1'b0;
    is_addi = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) is_add = 1'b1;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) is_sub = 1'b1;
      end
      7'b0010011: if (funct3 == 3'b000) is_addi = 1'b1;
      7'b0000011: if (funct3 == 3'b010) is_lw = 1'b1;
      7'b0100011: if (funct3 == 3'b010) is_sw = 1'b1;
      7'b1100011: begin
        if (funct3 == 3'b000) is_beq = 1'b1;
        else if (funct3 == 3'b001) is_bne = 1'b1;
      end
      default: ;
    endcase
    is_alu    = is_add | is_sub | is_addi;
    is_ldst   = is_lw | is_sw;
    is_branch = is_beq | is_bne;
    uses_rs1  = is_alu | is_ldst | is_branch;
    uses_rs2  = is_add | is_sub | is_sw | is_branch;
    uses_rd   = is_alu | is_lw;
    idx_bad   = (uses_rs1 && ({1'b0, rs1_idx} >= NREGS_W)) ||
                (uses_rs2 && ({1'b0, rs2_idx} >= NREGS_W)) ||
                (uses_rd  && ({1'b0, rd_idx}  >= NREGS_W));
    illegal   = !(is_alu | is_ldst | is_branch) || idx_bad;
  end

  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_sel;
  logic [XLEN-1:0] load_ext;
  logic            branch_taken;
  logic            xfer;

  assign xfer         = mem_req && mem_ack;
  assign imm_i        = XLEN'($signed(ir[31:20]));
  assign imm_s        = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_b        = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign load_ext     = XLEN'($signed(mem_rdata[31:0]));
  assign branch_taken = is_beq ? (a_q == b_q) : (a_q != b_q);
  assign a0           = regs[A0_IDX];

  // Operand read with x0 and out-of-range indices forced to zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    imm_sel = imm_i;
    if (rs1_idx != 5'd0 && {1'b0, rs1_idx} < NREGS_W) rs1_val = regs[rs1_idx[RIDX-1:0]];
    if (rs2_idx != 5'd0 && {1'b0, rs2_idx} < NREGS_W) rs2_val = regs[rs2_idx[RIDX-1:0]];
    if (is_sw) imm_sel = imm_s;
    else if (is_branch) imm_sel = imm_b;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state sequencing and memory port drive
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = b_q;
    case (state)
      S_FETCH: begin
        mem_req = req_en;
        if (xfer) state_next = S_DECODE;
      end
      S_DECODE: begin
`ifdef RV_ILLEGAL_TRAP_EN
        if (illegal) state_next = S_HALT;
        else         state_next = S_EXECUTE;
`else
        state_next = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        if (illegal)      state_next = S_FETCH;
        else if (is_alu)  state_next = S_WB;
        else if (is_ldst) state_next = S_MEM;
        else              state_next = S_FETCH;
      end
      S_MEM: begin
        mem_req  = req_en;
        mem_we   = is_sw;
        mem_addr = addr_q;
        if (xfer) state_next = is_sw ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

`ifdef RV_ILLEGAL_TRAP_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  assign retire = retire_q;

  // Datapath: PC, instruction and operand latches, register file and retire pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      result_q <= '0;
      addr_q   <= '0;
      retire_q <= 1'b0;
      req_en   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      req_en   <= 1'b1;
      retire_q <= 1'b0;
      case (state)
        S_FETCH: if (xfer) ir <= mem_rdata[31:0];
        S_DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_sel;
        end
        S_EXECUTE: begin
          if (illegal) begin
            pc       <= pc + FOUR;
            retire_q <= 1'b1;
          end else if (is_add) begin
            result_q <= a_q + b_q;
          end else if (is_sub) begin
            result_q <= a_q - b_q;
          end else if (is_addi) begin
            result_q <= a_q + imm_q;
          end else if (is_ldst) begin
            addr_q <= a_q + imm_q;
          end else begin
            pc       <= branch_taken ? (pc + imm_q) : (pc + FOUR);
            retire_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (xfer) begin
            if (is_sw) begin
              pc       <= pc + FOUR;
              retire_q <= 1'b1;
            end else begin
              result_q <= load_ext;
            end
          end
        end
        S_WB: begin
          if (rd_idx != 5'd0) regs[rd_idx[RIDX-1:0]] <= result_q;
          pc       <= pc + FOUR;
          retire_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
